// File: rtl/board_wrapper_pkg.sv
// Shared constants, FSM state type and seven-segment code table for the
// switch-to-decimal display path.
package board_wrapper_pkg;

    localparam int W_IN  = 17;
    localparam int N_DIG = 6;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segments, bit0 = a .. bit6 = g, indexed by decimal digit.
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Nibbles above 9 cannot come out of the converter; they blank the digit.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        return (d <= 4'd9) ? SEG_TABLE[d] : SEG_BLANK;
    endfunction

endpackage

// File: rtl/board_wrapper_if.sv
// Start/result handshake between the board wrapper and the sequential
// binary-to-BCD converter.
interface board_wrapper_if;
    import board_wrapper_pkg::*;

    logic                   start;
    logic [W_IN-1:0]        bin;
    logic                   busy;
    logic                   done;
    logic [4*N_DIG-1:0]     bcd;

    modport master (output start, bin, input busy, done, bcd);
    modport slave  (input start, bin, output busy, done, bcd);

endinterface

// File: rtl/board_wrapper_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, MSB first.
// bcd holds the last committed result; done stays high once a result has
// been committed since reset, so it doubles as the result-valid flag.
module bin2bcd_seq
    import board_wrapper_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    board_wrapper_if.slave  conv
);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [W_IN-1:0]        src;
    logic [4*N_DIG-1:0]     bcd_sr;
    logic [4*N_DIG-1:0]     bcd_adj;

    // Add 3 to every nibble >= 5 ahead of the next shift.
    always_comb begin
        bcd_adj = bcd_sr;
        for (int unsigned k = 0; k < N_DIG; k++) begin
            if (bcd_sr[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_sr[4*k +: 4] + 4'd3;
            end
        end
    end

    // Load / shift / commit FSM with registered busy, done and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            src       <= '0;
            bcd_sr    <= '0;
            conv.busy <= 1'b0;
            conv.done <= 1'b0;
            conv.bcd  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (conv.start) begin
                        src       <= conv.bin;
                        bcd_sr    <= '0;
                        cnt       <= '0;
                        conv.busy <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_sr, src} <= {bcd_adj[4*N_DIG-2:0], src, 1'b0};
                    cnt           <= cnt + 1'b1;
                    if (cnt == CNT_W'(W_IN - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    conv.bcd  <= bcd_sr;
                    conv.done <= 1'b1;
                    conv.busy <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/board_wrapper.sv
// DE2 top wrapper: SW[16:0] shown in decimal on HEX5..HEX0, switches
// mirrored on LEDR, converter status on LEDG, LCD held idle.
module board_wrapper
    import board_wrapper_pkg::*;
(
    input  logic        CLOCK_27,
    input  logic [17:0] SW,
    input  logic [3:0]  KEY,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7,
    output logic [17:0] LEDR,
    output logic [7:0]  LEDG,
    output logic [7:0]  LCD_DATA,
    output logic        LCD_RW,
    output logic        LCD_EN,
    output logic        LCD_RS,
    output logic        LCD_ON
);

    logic               rst;
    logic [W_IN-1:0]    sw_q;
    logic [W_IN-1:0]    src_q;
    logic [17:0]        ledr_q;
    logic [3:0]         key_q;
    logic               start;
    logic               valid;
    logic [4*N_DIG-1:0] result;
    logic [6:0]         seg [N_DIG];
    logic [3:0]         digit;
    logic               nz;

    board_wrapper_if conv ();

    assign rst = SW[17];

    // src_q remembers the value last handed to the converter, so a new
    // conversion starts only when nothing is valid yet or the switches moved.
    assign start      = !valid || (sw_q != src_q);
    assign conv.start = start;
    assign conv.bin   = sw_q;
    assign valid      = conv.done;
    assign result     = conv.bcd;

    bin2bcd_seq u_bin2bcd (
        .clk  (CLOCK_27),
        .rst  (rst),
        .conv (conv)
    );

    // Input registers and the tag of the value being converted.
    always_ff @(posedge CLOCK_27) begin
        if (rst) begin
            sw_q   <= '0;
            src_q  <= '0;
            ledr_q <= '0;
            key_q  <= '0;
        end else begin
            sw_q   <= SW[W_IN-1:0];
            ledr_q <= SW;
            key_q  <= ~KEY;
            if (start && !conv.busy) begin
                src_q <= sw_q;
            end
        end
    end

    // Digit decode with leading-zero blanking; units digit always shown.
    always_comb begin
        seg   = '{default: SEG_BLANK};
        digit = '0;
        nz    = 1'b0;
        for (int unsigned i = 0; i < N_DIG; i++) begin
            digit = result[4*(N_DIG-1-i) +: 4];
            nz    = nz | (digit != 4'd0);
            seg[N_DIG-1-i] = (valid && (nz || i == N_DIG-1)) ? seg_code(digit) : SEG_BLANK;
        end
    end

    assign HEX0 = seg[0];
    assign HEX1 = seg[1];
    assign HEX2 = seg[2];
    assign HEX3 = seg[3];
    assign HEX4 = seg[4];
    assign HEX5 = seg[5];
    assign HEX6 = SEG_BLANK;
    assign HEX7 = SEG_BLANK;

    assign LEDR = ledr_q;
    assign LEDG = {key_q, 2'b00, valid, conv.busy};

    assign LCD_DATA = 8'h00;
    assign LCD_RW   = 1'b0;
    assign LCD_EN   = 1'b0;
    assign LCD_RS   = 1'b0;
    assign LCD_ON   = 1'b0;

endmodule

// File: tb/tb_board_wrapper.sv
// Self-checking bench for board_wrapper plus a direct check of the
// converter sub-module through its handshake interface.
module tb_board_wrapper;
    import board_wrapper_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] sw;
    logic [3:0]  key;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic [17:0] ledr;
    logic [7:0]  ledg;
    logic [7:0]  lcd_data;
    logic        lcd_rw, lcd_en, lcd_rs, lcd_on;
    logic        urst;

    int checks = 0;
    int errors = 0;

    board_wrapper dut (
        .CLOCK_27 (clk),
        .SW       (sw),
        .KEY      (key),
        .HEX0     (hex0),
        .HEX1     (hex1),
        .HEX2     (hex2),
        .HEX3     (hex3),
        .HEX4     (hex4),
        .HEX5     (hex5),
        .HEX6     (hex6),
        .HEX7     (hex7),
        .LEDR     (ledr),
        .LEDG     (ledg),
        .LCD_DATA (lcd_data),
        .LCD_RW   (lcd_rw),
        .LCD_EN   (lcd_en),
        .LCD_RS   (lcd_rs),
        .LCD_ON   (lcd_on)
    );

    board_wrapper_if cif ();

    bin2bcd_seq u_unit (
        .clk  (clk),
        .rst  (urst),
        .conv (cif)
    );

    // ---------------- reference model ----------------
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected {HEX7..HEX0} for a decimal value, or all blank when not shown.
    function automatic logic [55:0] model_disp(input int v, input bit shown);
        logic [55:0] r;
        int p;
        r = {8{7'h7F}};
        p = 1;
        if (shown) begin
            for (int k = 0; k < 6; k++) begin
                if (k == 0 || v >= p) r[7*k +: 7] = seg_of((v / p) % 10);
                p = p * 10;
            end
        end
        return r;
    endfunction

    function automatic logic [23:0] model_bcd(input int v);
        logic [23:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < 6; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [55:0] disp();
        return {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_disp(input int v, output int n);
        n = 0;
        while (disp() !== model_disp(v, 1'b1) && n < 80) begin
            step();
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        sw  = 18'h20000 | 18'($urandom_range(0, 131071));
        key = 4'($urandom);
        repeat (3) step();
        checks++;
        if (disp() !== model_disp(0, 1'b0)) begin
            errors++; $display("FAIL reset_hex got %h want %h", disp(), model_disp(0, 1'b0));
        end
        checks++;
        if (ledg !== 8'h00) begin
            errors++; $display("FAIL reset_ledg got %h want 00", ledg);
        end
        checks++;
        if (ledr !== 18'h0) begin
            errors++; $display("FAIL reset_ledr got %h want 0", ledr);
        end
        checks++;
        if ({lcd_data, lcd_rw, lcd_en, lcd_rs, lcd_on} !== 12'h000) begin
            errors++; $display("FAIL reset_lcd got %h want 000", {lcd_data, lcd_rw, lcd_en, lcd_rs, lcd_on});
        end
    endtask

    task automatic test_release();
        int bad;
        int n;
        bad = 0;
        sw  = 18'd64;
        for (int i = 1; i <= 18; i++) begin
            step();
            if (disp() !== model_disp(0, 1'b0)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL release_blank got %0d nonblank cycles want 0", bad);
        end
        step();
        checks++;
        if (disp() !== model_disp(0, 1'b1)) begin
            errors++; $display("FAIL release_first_commit got %h want %h", disp(), model_disp(0, 1'b1));
        end
        wait_disp(64, n);
        checks++;
        if (disp() !== model_disp(64, 1'b1)) begin
            errors++; $display("FAIL release_64 got %h want %h", disp(), model_disp(64, 1'b1));
        end
        checks++;
        if (ledg[1] !== 1'b1) begin
            errors++; $display("FAIL release_valid got %b want 1", ledg[1]);
        end
    endtask

    task automatic test_latency();
        int first_busy;
        int busy_cnt;
        first_busy = 0;
        busy_cnt   = 0;
        sw = 18'd1000;
        for (int n = 1; n <= 24; n++) begin
            step();
            if (ledg[0] === 1'b1) begin
                busy_cnt++;
                if (first_busy == 0) first_busy = n;
            end
            if (n == 19) begin
                checks++;
                if (disp() !== model_disp(64, 1'b1)) begin
                    errors++; $display("FAIL latency_old got %h want %h", disp(), model_disp(64, 1'b1));
                end
            end
            if (n == 20) begin
                checks++;
                if (disp() !== model_disp(1000, 1'b1)) begin
                    errors++; $display("FAIL latency_new got %h want %h", disp(), model_disp(1000, 1'b1));
                end
            end
        end
        checks++;
        if (first_busy != 2 || busy_cnt != 18) begin
            errors++; $display("FAIL busy_window got start %0d len %0d want start 2 len 18", first_busy, busy_cnt);
        end
    endtask

    task automatic test_max();
        int n;
        int vals [2];
        vals[0] = 2047;
        vals[1] = 131071;
        foreach (vals[i]) begin
            sw = 18'(vals[i]);
            wait_disp(vals[i], n);
            checks++;
            if (disp() !== model_disp(vals[i], 1'b1)) begin
                errors++; $display("FAIL max_%0d got %h want %h", vals[i], disp(), model_disp(vals[i], 1'b1));
            end
        end
    endtask

    task automatic test_random();
        int n;
        int v;
        for (int i = 0; i < 6; i++) begin
            v   = (i == 0) ? 0 : int'($urandom_range(0, 131071));
            sw  = 18'(v);
            key = 4'($urandom);
            wait_disp(v, n);
            step();
            checks++;
            if (disp() !== model_disp(v, 1'b1)) begin
                errors++; $display("FAIL random_disp v=%0d got %h want %h", v, disp(), model_disp(v, 1'b1));
            end
            checks++;
            if (ledr !== 18'(v)) begin
                errors++; $display("FAIL random_ledr got %h want %h", ledr, 18'(v));
            end
            checks++;
            if (ledg !== {~key, 4'b0010}) begin
                errors++; $display("FAIL random_ledg got %h want %h", ledg, {~key, 4'b0010});
            end
        end
    endtask

    task automatic test_churn();
        int allowed[$];
        int bad;
        int v;
        bit ok;
        bad = 0;
        allowed.push_back(int'(sw[16:0]));
        for (int i = 0; i < 5; i++) begin
            v  = (i == 4) ? 0 : int'($urandom_range(1, 131071));
            sw = 18'(v);
            allowed.push_back(v);
            repeat ((i == 4) ? 80 : 5) begin
                step();
                ok = 1'b0;
                foreach (allowed[j]) if (disp() === model_disp(allowed[j], 1'b1)) ok = 1'b1;
                if (!ok) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL churn_partial got %0d bad cycles want 0", bad);
        end
        checks++;
        if (disp() !== model_disp(0, 1'b1)) begin
            errors++; $display("FAIL churn_final got %h want %h", disp(), model_disp(0, 1'b1));
        end
    endtask

    task automatic test_reset_mid();
        int v;
        int n;
        int first;
        v  = int'($urandom_range(10000, 131071));
        sw = 18'(v);
        repeat (6) step();
        checks++;
        if (ledg[0] !== 1'b1) begin
            errors++; $display("FAIL mid_busy got %b want 1", ledg[0]);
        end
        sw = 18'h20000 | 18'(v);
        step();
        checks++;
        if (ledg[1:0] !== 2'b00 || disp() !== model_disp(0, 1'b0)) begin
            errors++; $display("FAIL mid_abort got ledg %b hex %h want 00 blank", ledg[1:0], disp());
        end
        sw    = 18'(v);
        first = 0;
        for (int i = 1; i <= 30 && first == 0; i++) begin
            step();
            if (disp() !== model_disp(0, 1'b0)) first = i;
        end
        checks++;
        if (first != 19) begin
            errors++; $display("FAIL mid_first_commit got %0d want 19", first);
        end
        wait_disp(v, n);
        checks++;
        if (disp() !== model_disp(v, 1'b1)) begin
            errors++; $display("FAIL mid_value got %h want %h", disp(), model_disp(v, 1'b1));
        end
        key = 4'($urandom);
        step();
        checks++;
        if (ledg[7:4] !== ~key) begin
            errors++; $display("FAIL key_track got %h want %h", ledg[7:4], ~key);
        end
    endtask

    task automatic test_unit();
        int v;
        int n;
        urst = 1'b1;
        repeat (2) step();
        urst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = (i == 0) ? 0 : (i == 1) ? 131071 : (i == 2) ? 99999 : int'($urandom_range(0, 131071));
            cif.bin   = 17'(v);
            cif.start = 1'b1;
            step();
            cif.start = 1'b0;
            n = 0;
            while (cif.busy === 1'b1 && n < 30) begin
                step();
                n++;
            end
            checks++;
            if (cif.bcd !== model_bcd(v) || cif.done !== 1'b1 || n != 18) begin
                errors++; $display("FAIL unit_bcd v=%0d got %h done %b cyc %0d want %h 1 18",
                                   v, cif.bcd, cif.done, n, model_bcd(v));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sw        = 18'h20000;
        key       = 4'hF;
        urst      = 1'b1;
        cif.start = 1'b0;
        cif.bin   = '0;
        #1;
        test_reset();
        test_release();
        test_latency();
        test_max();
        test_random();
        test_churn();
        test_reset_mid();
        test_unit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
